indexer_sched: RTL

- Shares one 256-bit match-vector indexer (bit-vector to index-list converter with output FIFO) between N payload-engine lanes.
- Round-robin arbitrates lane requests and pulses the indexer load with the granted vector.
- Drains the indexer FIFO, stripping the per-load header entry and converting entries to rule indices.
- Emits a tagged rule-index stream to the rule-verification stage, one transaction per set bit, with end-of-vector marking.

---
 rtl/indexer_sched_if.sv | 37 +++
 rtl/indexer_sched.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/indexer_sched_if.sv
// Bundle of lane request, indexer and rule-output signals for indexer_sched.
// The master side is the scheduler; the slave side is lanes, indexer and downstream.
interface indexer_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 16
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*256-1:0]   req_vec;
  logic [NUM_REQ*TAG_W-1:0] req_tag;

  logic                     idx_ld;
  logic [255:0]             idx_din;
  logic                     idx_rd_en;
  logic                     idx_empty;
  logic [8:0]               idx_dout;

  logic                     out_valid;
  logic                     out_ready;
  logic [7:0]               out_rule;
  logic [TAG_W-1:0]         out_tag;
  logic [2:0]               out_lane;
  logic                     out_last;
  logic                     out_none;

  modport master (
    input  req_valid, req_vec, req_tag, idx_empty, idx_dout, out_ready,
    output req_ready, idx_ld, idx_din, idx_rd_en,
    output out_valid, out_rule, out_tag, out_lane, out_last, out_none
  );

  modport slave (
    output req_valid, req_vec, req_tag, idx_empty, idx_dout, out_ready,
    input  req_ready, idx_ld, idx_din, idx_rd_en,
    input  out_valid, out_rule, out_tag, out_lane, out_last, out_none
  );
endinterface

// File: rtl/indexer_sched.sv
// Round-robin scheduler sharing one 256-bit match-vector indexer between lanes,
// turning its FIFO entries into a tagged rule-index stream.
module indexer_sched #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  indexer_sched_if.master   bus,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LOAD, HDR, DRAIN, NONE} state_t;

  state_t           state_reg, state_next;
  logic [255:0]     vec_reg, vec_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic [2:0]       lane_reg, lane_next;
  logic [2:0]       rr_reg, rr_next;
  logic [8:0]       remaining_reg, remaining_next;
  logic             err_reg, err_next;

  logic [255:0]     lane_vec [NUM_REQ];
  logic [TAG_W-1:0] lane_tag [NUM_REQ];
  logic             gnt_any;
  logic [2:0]       gnt_idx;
  logic [255:0]     sel_vec;
  logic [TAG_W-1:0] sel_tag;
  logic [8:0]       pop_cnt;
  int               cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_vec[gi] = bus.req_vec[256*gi +: 256];
      assign lane_tag[gi] = bus.req_tag[TAG_W*gi +: TAG_W];
    end
  endgenerate

  // Scan from the highest offset down so the nearest lane at/after rr_reg wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = 3'(cand);
      end
    end
  end

  always_comb begin
    sel_vec = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 3'(i)) begin
        sel_vec = lane_vec[i];
        sel_tag = lane_tag[i];
      end
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < 256; i++) pop_cnt = pop_cnt + {8'd0, vec_reg[i]};
  end

  always_comb begin
    state_next     = state_reg;
    vec_next       = vec_reg;
    tag_next       = tag_reg;
    lane_next      = lane_reg;
    rr_next        = rr_reg;
    remaining_next = remaining_reg;
    err_next       = err_reg;
    bus.req_ready  = '0;
    bus.idx_ld     = 1'b0;
    bus.idx_din    = '0;
    bus.idx_rd_en  = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_rule   = '0;
    bus.out_last   = 1'b0;
    bus.out_none   = 1'b0;

    case (state_reg)
      IDLE: begin
        // req_ready is combinational on req_valid, so keep it quiet while in reset
        if (gnt_any && rst_n) begin
          for (int i = 0; i < NUM_REQ; i++) bus.req_ready[i] = (gnt_idx == 3'(i));
          vec_next   = sel_vec;
          tag_next   = sel_tag;
          lane_next  = gnt_idx;
          rr_next    = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        bus.idx_ld     = 1'b1;
        bus.idx_din    = vec_reg;
        remaining_next = pop_cnt;
        state_next     = HDR;
      end
      HDR: begin
        if (!bus.idx_empty) begin
          bus.idx_rd_en = 1'b1;
          if (bus.idx_dout != 9'd0) err_next = 1'b1;
          state_next = (remaining_reg == 9'd0) ? NONE : DRAIN;
        end
      end
      DRAIN: begin
        bus.out_valid = !bus.idx_empty;
        bus.out_rule  = 8'(bus.idx_dout - 9'd1);
        bus.out_last  = (remaining_reg == 9'd1);
        // A zero entry mid-vector is malformed; flag it but keep the stream aligned.
        if (!bus.idx_empty && bus.idx_dout == 9'd0) err_next = 1'b1;
        if (bus.out_valid && bus.out_ready) begin
          bus.idx_rd_en  = 1'b1;
          remaining_next = remaining_reg - 9'd1;
          if (remaining_reg == 9'd1) state_next = IDLE;
        end
      end
      NONE: begin
        bus.out_valid = 1'b1;
        bus.out_none  = 1'b1;
        bus.out_last  = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      vec_reg       <= '0;
      tag_reg       <= '0;
      lane_reg      <= '0;
      rr_reg        <= '0;
      remaining_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      vec_reg       <= vec_next;
      tag_reg       <= tag_next;
      lane_reg      <= lane_next;
      rr_reg        <= rr_next;
      remaining_reg <= remaining_next;
      err_reg       <= err_next;
    end
  end

  assign bus.out_tag  = tag_reg;
  assign bus.out_lane = lane_reg;
  assign busy         = (state_reg != IDLE);
  assign err          = err_reg;

endmodule
